modexp_sequencer: RTL and testbench

//  Computes result = base^exponent mod modulus by left-to-right square-and-multiply.

---
 rtl/modexp_sequencer_if.sv | 30 +++
 rtl/modexp_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_modexp_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/modexp_sequencer_if.sv
// rtl/modexp_sequencer_if.sv - multiplier bus between modexp_sequencer and one modular multiplier
// Purpose: bundles the launch, operand and result signals of a single interleaved
//          modular multiplier so the sequencer and the multiplier share one port.
// Signals:
//   mul_reset   sequencer -> multiplier  1 = hold/restart; release starts a product
//   mul_a       sequencer -> multiplier  operand a (bit-scanned operand)
//   mul_b       sequencer -> multiplier  operand b, always < mul_n when launched
//   mul_n       sequencer -> multiplier  modulus
//   mul_ready   multiplier -> sequencer  product available
//   mul_result  multiplier -> sequencer  a*b mod n, valid while mul_ready==1
interface modexp_sequencer_if #(
  parameter int WIDTH = 128
);
  logic             mul_reset;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_n;
  logic             mul_ready;
  logic [WIDTH-1:0] mul_result;

  modport master (
    output mul_reset, mul_a, mul_b, mul_n,
    input  mul_ready, mul_result
  );

  modport slave (
    input  mul_reset, mul_a, mul_b, mul_n,
    output mul_ready, mul_result
  );
endinterface

// File: rtl/modexp_sequencer.sv
// rtl/modexp_sequencer.sv - left-to-right square-and-multiply sequencer for base^exponent mod modulus
// Purpose: drives one external modular multiplier through REDUCE / SQ / MUL products.
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   start           request, sampled only when idle; base/exponent/modulus captured same cycle
//   base/exponent/modulus  operands; modulus must be nonzero with top three bits clear
//   busy            high from the cycle after an accepted start through the done cycle
//   done            one-cycle pulse when result/err are valid
//   err, result     held until next accepted start; result is 0 when err
//   mul             multiplier bus (master side)
module modexp_sequencer #(
  parameter int WIDTH       = 128,
  parameter int MUL_TIMEOUT = 600
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WIDTH-1:0]          base,
  input  logic [WIDTH-1:0]          exponent,
  input  logic [WIDTH-1:0]          modulus,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [WIDTH-1:0]          result,
  modexp_sequencer_if.master        mul
);
  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(MUL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_FIND, S_LAUNCH, S_WAIT, S_NEXT, S_DONE
  } state_e;

  // Which product the shared LAUNCH/WAIT pair is currently running.
  typedef enum logic [1:0] {OP_RED, OP_SQ, OP_MUL} op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] base_r_q, base_r_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] mul_a_c, mul_b_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_RED;
      base_q   <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      acc_q    <= '0;
      base_r_q <= '0;
      result_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      mod_q    <= mod_d;
      acc_q    <= acc_d;
      base_r_q <= base_r_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    base_d   = base_q;
    exp_d    = exp_q;
    mod_d    = mod_q;
    acc_d    = acc_q;
    base_r_d = base_r_q;
    result_d = result_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d   = base;
          exp_d    = exponent;
          mod_d    = modulus;
          err_d    = 1'b0;
          result_d = '0;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        // Top three modulus bits must be clear so the multiplier's running sum cannot overflow.
        if (mod_q == '0 || mod_q[WIDTH-1 -: 3] != 3'b000) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = S_DONE;
        end else if (mod_q == WIDTH'(1)) begin
          result_d = '0;
          state_d  = S_DONE;
        end else begin
          idx_d   = IW'(WIDTH - 1);
          acc_d   = WIDTH'(1);
          state_d = S_FIND;
        end
      end
      S_FIND: begin
        if (exp_q[idx_q]) begin
          op_d    = OP_RED;
          state_d = S_LAUNCH;
        end else if (idx_q == '0) begin
          result_d = WIDTH'(1);
          state_d  = S_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Ready in the first WAIT cycle may be stale from before the restart, so it is skipped.
        if (mul.mul_ready && cnt_q != '0) begin
          case (op_q)
            OP_RED: begin
              base_r_d = mul.mul_result;
              op_d     = OP_SQ;
              state_d  = S_LAUNCH;
            end
            OP_SQ: begin
              acc_d = mul.mul_result;
              if (exp_q[idx_q]) begin
                op_d    = OP_MUL;
                state_d = S_LAUNCH;
              end else begin
                state_d = S_NEXT;
              end
            end
            default: begin
              acc_d   = mul.mul_result;
              state_d = S_NEXT;
            end
          endcase
        end else if (cnt_q == CW'(MUL_TIMEOUT)) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_NEXT: begin
        if (idx_q == '0) begin
          result_d = acc_q;
          state_d  = S_DONE;
        end else begin
          idx_d   = idx_q - IW'(1);
          op_d    = OP_SQ;
          state_d = S_LAUNCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operands are a pure function of the active product so they stay constant through WAIT.
  always_comb begin
    mul_a_c = '0;
    mul_b_c = '0;
    if (state_q == S_LAUNCH || state_q == S_WAIT) begin
      case (op_q)
        OP_RED: begin
          mul_a_c = base_q;
          mul_b_c = WIDTH'(1);
        end
        OP_SQ: begin
          mul_a_c = acc_q;
          mul_b_c = acc_q;
        end
        default: begin
          mul_a_c = acc_q;
          mul_b_c = base_r_q;
        end
      endcase
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign err            = err_q;
  assign result         = result_q;
  assign mul.mul_reset  = (state_q != S_WAIT);
  assign mul.mul_a      = mul_a_c;
  assign mul.mul_b      = mul_b_c;
  assign mul.mul_n      = busy ? mod_q : '0;
endmodule

// File: tb/tb_modexp_sequencer.sv
// tb/tb_modexp_sequencer.sv - scoreboard bench for modexp_sequencer with a behavioural multiplier
module tb_modexp_sequencer;
  localparam int WIDTH       = 128;
  localparam int MUL_TIMEOUT = 600;

  typedef logic [WIDTH-1:0] word_t;
  typedef struct {
    word_t res;
    logic  err;
    int    launches;
    int    waits;
    int    cyc;
  } exp_t;

  logic  clk = 1'b0;
  logic  reset;
  logic  start;
  word_t base, exponent, modulus;
  logic  busy, done, err;
  word_t result;

  modexp_sequencer_if #(.WIDTH(WIDTH)) mul_if ();

  modexp_sequencer #(.WIDTH(WIDTH), .MUL_TIMEOUT(MUL_TIMEOUT)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result),
    .mul      (mul_if)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  exp_t  sb_q[$];
  word_t cur_n;
  bit    hang = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic word_t mulmod(input word_t a, input word_t b, input word_t n);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    return word_t'(p % {{WIDTH{1'b0}}, n});
  endfunction

  // Right-to-left binary exponentiation plus the product-count formula.
  function automatic exp_t ref_model(input word_t b, input word_t e, input word_t n);
    exp_t  r;
    word_t acc, sq;
    int    msb, pop;
    r.waits = -1; r.cyc = -1; r.err = 1'b0; r.launches = 0; r.res = '0;
    if (n == '0 || n[WIDTH-1 -: 3] != 3'b000) begin
      r.err = 1'b1; r.cyc = 2;
    end else if (n == word_t'(1)) begin
      r.cyc = 2;
    end else if (e == '0) begin
      r.res = word_t'(1); r.cyc = WIDTH + 2;
    end else begin
      acc = word_t'(1); sq = b % n; msb = 0; pop = 0;
      for (int i = 0; i < WIDTH; i++) begin
        if (e[i]) begin
          acc = mulmod(acc, sq, n); msb = i; pop++;
        end
        sq = mulmod(sq, sq, n);
      end
      r.res = acc;
      r.launches = 1 + (msb + 1) + pop;
    end
    return r;
  endfunction

  task automatic push_exp(input word_t r, input logic e, input int l, input int w, input int c);
    exp_t x;
    x.res = r; x.err = e; x.launches = l; x.waits = w; x.cyc = c;
    sb_q.push_back(x);
  endtask

  // Behavioural multiplier: random latency after reset release, ready held until next reset.
  int mcnt, mlat;
  always @(negedge clk) begin
    if (mul_if.mul_reset) begin
      mul_if.mul_ready = 1'b0;
      mcnt = 0;
      mlat = $urandom_range(1, 5);
    end else begin
      mcnt++;
      if (!hang && mcnt >= mlat && mul_if.mul_n != '0) begin
        mul_if.mul_ready  = 1'b1;
        mul_if.mul_result = mulmod(mul_if.mul_a, mul_if.mul_b, mul_if.mul_n);
      end
    end
  end

  // Monitor: counts launches/WAIT cycles/busy cycles and checks each done against the scoreboard.
  int   launch_cnt = 0, wait_run = 0, busy_run = 0;
  logic prev_mr = 1'b1, prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t x;
    if (reset) begin
      launch_cnt = 0; wait_run = 0; busy_run = 0; prev_mr = 1'b1; prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        chk("done_one_cycle", done, 0);
        chk("busy_low_after_done", busy, 0);
      end
      if (busy) busy_run++;
      if (prev_mr && !mul_if.mul_reset) begin
        launch_cnt++;
        wait_run = 0;
        chk("launch_b_lt_n", mul_if.mul_b < mul_if.mul_n, 1);
        chk("launch_n_captured", mul_if.mul_n, cur_n);
        chk("launch_busy", busy, 1);
      end
      if (!mul_if.mul_reset) wait_run++;
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done_queue", sb_q.size(), 1);
        end else begin
          x = sb_q.pop_front();
          chk("result", result, x.res);
          chk("err", err, x.err);
          chk("launches", launch_cnt, x.launches);
          chk("busy_at_done", busy, 1);
          if (x.waits >= 0) chk("timeout_wait_cycles", wait_run, x.waits);
          if (x.cyc >= 0) chk("busy_cycles", busy_run, x.cyc);
        end
        launch_cnt = 0;
        busy_run = 0;
      end
      prev_mr = mul_if.mul_reset;
      prev_done = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input word_t b, input word_t e, input word_t n, input bit poke_busy);
    int cyc;
    base = b; exponent = e; modulus = n; cur_n = n; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 20000) begin
      cyc++;
      if (poke_busy && cyc == 3) begin
        base = ~b; exponent = e + word_t'(1); modulus = n + word_t'(2); start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("op_finished", busy, 0);
  endtask

  initial begin
    word_t one, mask, b, e, n;
    int    w, cyc;
    one  = word_t'(1);
    mask = {3'b000, {(WIDTH-3){1'b1}}};
    reset = 1'b1; start = 1'b0; base = '0; exponent = '0; modulus = '0; cur_n = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_mul_reset", mul_if.mul_reset, 1);
    chk("rst_mul_a", mul_if.mul_a, 0);
    chk("rst_mul_b", mul_if.mul_b, 0);
    chk("rst_mul_n", mul_if.mul_n, 0);

    push_exp(word_t'(445), 1'b0, 8, -1, -1);
    go(word_t'(4), word_t'(13), word_t'(497), 1'b0);
    push_exp(word_t'(1), 1'b0, 4, -1, -1);
    go(word_t'(1000), word_t'(2), word_t'(7), 1'b0);
    push_exp(word_t'(1), 1'b0, 0, -1, WIDTH + 2);
    go(word_t'(12345), '0, word_t'(7), 1'b0);
    push_exp('0, 1'b0, 0, -1, 2);
    go(word_t'(99), word_t'(77), word_t'(1), 1'b0);
    push_exp('0, 1'b1, 0, -1, 2);
    go(word_t'(5), word_t'(3), '0, 1'b0);
    push_exp('0, 1'b1, 0, -1, 2);
    go(word_t'(5), word_t'(3), one << 126, 1'b0);

    hang = 1'b1;
    push_exp('0, 1'b1, 1, MUL_TIMEOUT + 1, -1);
    go(word_t'(4), word_t'(13), word_t'(497), 1'b0);
    hang = 1'b0;
    push_exp(word_t'(445), 1'b0, 8, -1, -1);
    go(word_t'(4), word_t'(13), word_t'(497), 1'b0);

    push_exp(word_t'(445), 1'b0, 8, -1, -1);
    go(word_t'(4), word_t'(13), word_t'(497), 1'b1);

    sb_q.push_back(ref_model(word_t'(3), one << (WIDTH - 1), word_t'(1000003)));
    go(word_t'(3), one << (WIDTH - 1), word_t'(1000003), 1'b0);

    // Start presented in the DONE cycle must be dropped.
    push_exp(word_t'(445), 1'b0, 8, -1, -1);
    base = word_t'(4); exponent = word_t'(13); modulus = word_t'(497); cur_n = modulus; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20000) begin cyc++; tick(); end
    chk("reached_done", done, 1);
    base = word_t'(2); exponent = word_t'(5); modulus = word_t'(7); start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_start_ignored_a", busy, 0);
    tick();
    chk("done_start_ignored_b", busy, 0);
    chk("result_held", result, 445);

    // Reset during the first SQ product aborts without a done pulse.
    base = word_t'(5); exponent = word_t'(8'hFF); modulus = word_t'(1009); cur_n = modulus; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(launch_cnt >= 2 && !mul_if.mul_reset) && cyc < 5000) begin cyc++; tick(); end
    chk("abort_in_sq_wait", launch_cnt == 2 && !mul_if.mul_reset, 1);
    reset = 1'b1;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_mul_reset", mul_if.mul_reset, 1);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    chk("abort_result", result, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) begin
      b = {$urandom(), $urandom(), $urandom(), $urandom()};
      n = {$urandom(), $urandom(), $urandom(), $urandom()} & mask;
      if (i % 4 == 0) n = n >> $urandom_range(0, 120);
      if (n < word_t'(2)) n = word_t'(3);
      w = $urandom_range(1, WIDTH);
      e = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (w < WIDTH) e = e & ((one << w) - one);
      sb_q.push_back(ref_model(b, e, n));
      go(b, e, n, 1'b0);
    end

    repeat (3) tick();
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
